// File: rtl/tx_symbol_source.sv
// rtl/tx_symbol_source.sv - multi-channel LFSR M-ASK test-symbol source with upsampler
//
// Purpose:
//   One Fibonacci LFSR feeds a natural-binary M-ASK mapper per channel. The
//   mapped symbols are upsampled by UPS, either by zero-stuffing (default) or
//   by zero-order hold, before going to the pulse-shaping filters.
//   Also reports the LFSR period and recovers from the all-zero lock-up state.
//
// Ports:
//   sys_clk     in   system clock
//   reset       in   asynchronous, active-high reset
//   sam_clk_en  in   one-cycle sample strobe
//   load        in   reload SEED and restart phase (only with sam_clk_en)
//   y           out  N_CH*DW signed samples, channel c at [c*DW +: DW]
//   sym_clk_en  out  one-cycle pulse on each new symbol
//   cycle       out  one-cycle pulse when the LFSR returns to SEED
//   lfsr_state  out  current LFSR state
//
// Configuration macro:
//   TX_SRC_ZOH_EN  defined: zero-order hold upsampler; undefined: zero-stuffing
module tx_symbol_source #(
  parameter int                  LFSR_LEN   = 22,
  parameter logic [LFSR_LEN-1:0] TAPS       = LFSR_LEN'(22'h300000),
  parameter logic [LFSR_LEN-1:0] SEED       = {LFSR_LEN{1'b1}},
  parameter int                  N_CH       = 2,
  parameter int                  BPS        = 2,
  parameter int                  UPS        = 4,
  parameter int                  DW         = 18,
  parameter int                  LEVEL_STEP = 32768
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 sam_clk_en,
  input  logic                 load,
  output logic [N_CH*DW-1:0]   y,
  output logic                 sym_clk_en,
  output logic                 cycle,
  output logic [LFSR_LEN-1:0]  lfsr_state
);

  // Phase counter needs at least one bit even when UPS == 1.
  localparam int PH_W = (UPS > 1) ? $clog2(UPS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(UPS - 1);

  // Mapper arithmetic runs 4 bits wider than the output so that the largest
  // level (7 * LEVEL_STEP for 8-ASK) can be detected and saturated.
  localparam int MW = DW + 4;
  localparam logic signed [MW-1:0] ODD_W   = MW'((2 ** BPS) - 1);
  localparam logic signed [MW-1:0] STEP_W  = MW'(LEVEL_STEP);
  localparam logic signed [MW-1:0] SAT_MAX = {5'b00000, {(DW-1){1'b1}}};
  localparam logic signed [MW-1:0] SAT_MIN = {5'b11111, {(DW-1){1'b0}}};

  logic [LFSR_LEN-1:0] state_q;
  logic [LFSR_LEN-1:0] state_step;
  logic                feedback;
  logic [PH_W-1:0]     ph_q;
  logic [PH_W-1:0]     ph_next;
  logic [N_CH*DW-1:0]  y_q;
  logic [N_CH*DW-1:0]  sym_levels;
  logic                sym_q;
  logic                cycle_q;
  logic                sym_event;

  // Natural-binary code k -> (2k - (2^BPS - 1)) * LEVEL_STEP, saturated to DW.
  function automatic logic [DW-1:0] map_level(input logic [BPS-1:0] code);
    logic signed [MW-1:0] lvl;
    logic signed [MW-1:0] prod;
    lvl  = $signed({{(MW-BPS-1){1'b0}}, code, 1'b0}) - ODD_W;
    prod = lvl * STEP_W;
    if (prod > SAT_MAX) begin
      map_level = SAT_MAX[DW-1:0];
    end else if (prod < SAT_MIN) begin
      map_level = SAT_MIN[DW-1:0];
    end else begin
      map_level = prod[DW-1:0];
    end
  endfunction

  // Each channel takes its own BPS-bit slice of the pre-step state.
  for (genvar c = 0; c < N_CH; c++) begin : g_map
    assign sym_levels[c*DW +: DW] = map_level(state_q[c*BPS +: BPS]);
  end

  assign feedback = ^(state_q & TAPS);

  // The all-zero state is a fixed point of the XOR feedback; escape it by
  // jumping back to SEED. The zero state itself maps to code 0 levels.
  always_comb begin
    state_step = {state_q[LFSR_LEN-2:0], feedback};
    if (state_q == '0) begin
      state_step = SEED;
    end
  end

  always_comb begin
    ph_next = ph_q + 1'b1;
    if (ph_q == PH_LAST) begin
      ph_next = '0;
    end
  end

  // load takes priority over a symbol event on the same strobe.
  assign sym_event = sam_clk_en && !load && (ph_q == '0);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
      ph_q    <= '0;
      y_q     <= '0;
      sym_q   <= 1'b0;
      cycle_q <= 1'b0;
    end else begin
      sym_q   <= 1'b0;
      cycle_q <= 1'b0;
      if (sam_clk_en) begin
        if (load) begin
          state_q <= SEED;
          ph_q    <= '0;
          y_q     <= '0;
        end else begin
          ph_q <= ph_next;
          if (sym_event) begin
            y_q     <= sym_levels;
            state_q <= state_step;
            sym_q   <= 1'b1;
            cycle_q <= (state_step == SEED);
          end else begin
`ifdef TX_SRC_ZOH_EN
            y_q <= y_q;
`else
            y_q <= '0;
`endif
          end
        end
      end
    end
  end

  assign y          = y_q;
  assign sym_clk_en = sym_q;
  assign cycle      = cycle_q;
  assign lfsr_state = state_q;

endmodule

// File: tb/tb_tx_symbol_source.sv
// tb/tb_tx_symbol_source.sv - self-checking bench for tx_symbol_source
module tb_tx_symbol_source;

  logic sys_clk = 1'b0;
  logic reset = 1'b0;
  logic sam_clk_en = 1'b0;
  logic load = 1'b0;

  logic [35:0] y_a, y_b;
  logic [17:0] y_c, y_d;
  logic sym_a, sym_b, sym_c, sym_d;
  logic cyc_a, cyc_b, cyc_c, cyc_d;
  logic [21:0] st_a, st_c, st_d;
  logic [3:0] st_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  tx_symbol_source u_a (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .load(load),
    .y(y_a), .sym_clk_en(sym_a), .cycle(cyc_a), .lfsr_state(st_a));

  tx_symbol_source #(.LFSR_LEN(4), .TAPS(4'hC), .SEED(4'hF), .UPS(1)) u_b (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .load(load),
    .y(y_b), .sym_clk_en(sym_b), .cycle(cyc_b), .lfsr_state(st_b));

  tx_symbol_source #(.BPS(3), .N_CH(1), .LEVEL_STEP(16384), .UPS(1)) u_c (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .load(load),
    .y(y_c), .sym_clk_en(sym_c), .cycle(cyc_c), .lfsr_state(st_c));

  tx_symbol_source #(.BPS(3), .N_CH(1), .LEVEL_STEP(32768), .UPS(1)) u_d (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .load(load),
    .y(y_d), .sym_clk_en(sym_d), .cycle(cyc_d), .lfsr_state(st_d));

  // Reference model parameters, one entry per instance a,b,c,d.
  localparam int          P_LEN [4] = '{22, 4, 22, 22};
  localparam logic [31:0] P_TAPS[4] = '{32'h300000, 32'hC, 32'h300000, 32'h300000};
  localparam logic [31:0] P_SEED[4] = '{32'h3FFFFF, 32'hF, 32'h3FFFFF, 32'h3FFFFF};
  localparam int          P_NCH [4] = '{2, 2, 1, 1};
  localparam int          P_BPS [4] = '{2, 2, 3, 3};
  localparam int          P_UPS [4] = '{4, 1, 1, 1};
  localparam int          P_STEP[4] = '{32768, 32768, 16384, 32768};

  logic [31:0] m_st [4];
  int          m_ph [4];
  int          m_y  [4][2];
  bit          m_sym[4];
  bit          m_cyc[4];

  typedef struct {
    int ya0, ya1, yb0, yb1, yc, yd;
    bit syma, cyca, symb, cycb, symc;
    logic [31:0] sta, stb, stc;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input int len,
                                            input logic [31:0] taps, input logic [31:0] seed);
    logic fb;
    logic [31:0] mask;
    fb = 1'b0;
    if (s == 0) return seed;
    for (int i = 0; i < len; i++) if (taps[i]) fb = fb ^ s[i];
    mask = (len == 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
    return ((s << 1) | {31'd0, fb}) & mask;
  endfunction

  function automatic int map_lvl(input int code, input int bps, input int step);
    longint v;
    v = longint'(2 * code - ((1 << bps) - 1)) * longint'(step);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_st[d] = P_SEED[d]; m_ph[d] = 0;
      m_y[d][0] = 0; m_y[d][1] = 0;
      m_sym[d] = 1'b0; m_cyc[d] = 1'b0;
    end
  endtask

  task automatic model_step(input bit sam, input bit ld);
    logic [31:0] nxt;
    int code;
    for (int d = 0; d < 4; d++) begin
      m_sym[d] = 1'b0; m_cyc[d] = 1'b0;
      if (sam) begin
        if (ld) begin
          m_st[d] = P_SEED[d]; m_ph[d] = 0;
          m_y[d][0] = 0; m_y[d][1] = 0;
        end else begin
          if (m_ph[d] == 0) begin
            for (int c = 0; c < P_NCH[d]; c++) begin
              code = int'((m_st[d] >> (c * P_BPS[d])) & ((32'd1 << P_BPS[d]) - 1));
              m_y[d][c] = map_lvl(code, P_BPS[d], P_STEP[d]);
            end
            nxt = lfsr_next(m_st[d], P_LEN[d], P_TAPS[d], P_SEED[d]);
            m_cyc[d] = (nxt == P_SEED[d]);
            m_st[d] = nxt;
            m_sym[d] = 1'b1;
          end else begin
            m_y[d][0] = 0; m_y[d][1] = 0;
          end
          m_ph[d] = (m_ph[d] + 1) % P_UPS[d];
        end
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle, push the model's expectation, compare after the edge.
  task automatic step(input bit sam, input bit ld);
    exp_t e;
    @(negedge sys_clk);
    sam_clk_en = sam;
    load = ld;
    model_step(sam, ld);
    e.ya0 = m_y[0][0]; e.ya1 = m_y[0][1]; e.yb0 = m_y[1][0]; e.yb1 = m_y[1][1];
    e.yc = m_y[2][0]; e.yd = m_y[3][0];
    e.syma = m_sym[0]; e.cyca = m_cyc[0]; e.symb = m_sym[1]; e.cycb = m_cyc[1];
    e.symc = m_sym[2];
    e.sta = m_st[0]; e.stb = m_st[1]; e.stc = m_st[2];
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    e = sb.pop_front();
    chk("sb_a_y0", int'($signed(y_a[17:0])), e.ya0);
    chk("sb_a_y1", int'($signed(y_a[35:18])), e.ya1);
    chk("sb_a_sym", sym_a, e.syma);
    chk("sb_a_cycle", cyc_a, e.cyca);
    chk("sb_a_state", st_a, e.sta);
    chk("sb_b_y0", int'($signed(y_b[17:0])), e.yb0);
    chk("sb_b_y1", int'($signed(y_b[35:18])), e.yb1);
    chk("sb_b_sym", sym_b, e.symb);
    chk("sb_b_cycle", cyc_b, e.cycb);
    chk("sb_b_state", st_b, e.stb);
    chk("sb_c_y", int'($signed(y_c)), e.yc);
    chk("sb_c_sym", sym_c, e.symc);
    chk("sb_c_state", st_c, e.stc);
    chk("sb_d_y", int'($signed(y_d)), e.yd);
  endtask

  typedef struct {
    bit sam;
    bit ld;
    int y0;
    int y1;
    bit sym;
    logic [21:0] st;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[16];
    logic [3:0] per_seq[15];
    int lvl4[4];
    int v, max_c, min_c, max_d, min_d, n_cyc_b;
    logic [7:0] seen_c;

    lvl4 = '{-98304, -32768, 32768, 98304};
    per_seq = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};

    // Default instance, strobe every second cycle: two full symbols.
    for (int i = 0; i < 16; i++) begin
      tab[i].sam = (i % 2 == 0);
      tab[i].ld  = 1'b0;
      tab[i].sym = (i == 0) || (i == 8);
      tab[i].st  = (i < 8) ? 22'h3FFFFE : 22'h3FFFFC;
      if (i < 2)       begin tab[i].y0 = 98304; tab[i].y1 = 98304; end
      else if (i < 8)  begin tab[i].y0 = 0;     tab[i].y1 = 0;     end
      else if (i < 10) begin tab[i].y0 = 32768; tab[i].y1 = 98304; end
      else             begin tab[i].y0 = 0;     tab[i].y1 = 0;     end
    end

    // Asynchronous reset without a clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_y", y_a, 0);
    chk("rst_sym", sym_a, 0);
    chk("rst_cycle", cyc_a, 0);
    chk("rst_state", st_a, 22'h3FFFFF);
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tab[i].sam, tab[i].ld);
      chk($sformatf("tab%0d_y0", i), int'($signed(y_a[17:0])), tab[i].y0);
      chk($sformatf("tab%0d_y1", i), int'($signed(y_a[35:18])), tab[i].y1);
      chk($sformatf("tab%0d_sym", i), sym_a, tab[i].sym);
      chk($sformatf("tab%0d_state", i), st_a, tab[i].st);
    end

    // Load at ph=2 of the third symbol.
    step(1'b1, 1'b0);
    chk("sym3_y0", int'($signed(y_a[17:0])), -98304);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("load_y", y_a, 0);
    chk("load_state", st_a, 22'h3FFFFF);
    chk("load_sym", sym_a, 0);
    step(1'b0, 1'b1);
    chk("load_nostrobe_state", st_a, 22'h3FFFFF);
    chk("load_nostrobe_y", y_a, 0);
    step(1'b1, 1'b0);
    chk("after_load_y0", int'($signed(y_a[17:0])), 98304);
    chk("after_load_y1", int'($signed(y_a[35:18])), 98304);
    chk("after_load_sym", sym_a, 1);

    // Period of the 4-bit LFSR and the 8-ASK mapping sweep, strobe every cycle.
    step(1'b1, 1'b1);
    max_c = -1000000; min_c = 1000000; max_d = -1000000; min_d = 1000000;
    seen_c = 8'h00; n_cyc_b = 0;
    for (int i = 0; i < 90; i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("per%0d_state", i), st_b, per_seq[(i + 1) % 15]);
      chk($sformatf("per%0d_cycle", i), cyc_b, ((i % 15) == 14) ? 1 : 0);
      chk($sformatf("per%0d_y0", i), int'($signed(y_b[17:0])), lvl4[per_seq[i % 15][1:0]]);
      chk($sformatf("per%0d_y1", i), int'($signed(y_b[35:18])), lvl4[per_seq[i % 15][3:2]]);
      chk($sformatf("per%0d_nonzero", i), (st_b != 4'h0) ? 1 : 0, 1);
      if (cyc_b) n_cyc_b++;
      if (sym_c) begin
        v = int'($signed(y_c));
        if (v > max_c) max_c = v;
        if (v < min_c) min_c = v;
        if (v >= -114688 && v <= 114688 && ((v + 114688) % 32768) == 0)
          seen_c[(v + 114688) / 32768] = 1'b1;
      end
      if (sym_d) begin
        v = int'($signed(y_d));
        if (v > max_d) max_d = v;
        if (v < min_d) min_d = v;
      end
    end
    chk("period_pulses", n_cyc_b, 6);
    chk("sweep_codes_seen", seen_c, 8'hFF);
    chk("sweep_max", max_c, 114688);
    chk("sweep_min", min_c, -114688);
    chk("sat_max", max_d, 131071);
    chk("sat_min", min_d, -131072);

    // Reset asserted mid-symbol, between clock edges.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_y", y_a, 0);
    chk("midrst_sym", sym_a, 0);
    chk("midrst_cycle", cyc_a, 0);
    chk("midrst_state", st_a, 22'h3FFFFF);
    chk("midrst_state_b", st_b, 4'hF);
    model_reset();
    @(negedge sys_clk);
    sam_clk_en = 1'b0;
    load = 1'b0;
    @(negedge sys_clk);
    reset = 1'b0;
    step(1'b0, 1'b0);
    chk("postrst_idle_y", y_a, 0);
    step(1'b1, 1'b0);
    chk("postrst_y0", int'($signed(y_a[17:0])), 98304);
    chk("postrst_y1", int'($signed(y_a[35:18])), 98304);
    chk("postrst_sym", sym_a, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
